cla_pipe_adder: RTL



---
 rtl/cla_pipe_adder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor built from 4-bit groups.
// Each stage resolves GPS groups and registers the carry to the next.
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GPS   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             P,
  output logic             G
);

  localparam int NG = WIDTH / 4;
  localparam int NS = (NG + GPS - 1) / GPS;

  // op_a/op_b: skewed operands (op_b already inverted for sub)
  // res: result bits resolved so far, cy: running carry
  // pp/gg: running word propagate/generate, cm: carry into msb
  typedef struct packed {
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic             cy;
    logic             pp;
    logic             gg;
    logic             cm;
  } st_t;

  st_t           r  [NS];
  st_t           nx [NS];
  st_t           in_st;
  logic [NS-1:0] vld;
  logic          adv;
  logic          take;

  function automatic st_t calc(input int s, input st_t x);
    st_t        y;
    logic [3:0] p4;
    logic [3:0] g4;
    logic       c0, c1, c2, c3;
    logic       gp, gg;
    int         k;
    y = x;
    for (int j = 0; j < GPS; j++) begin
      k = s * GPS + j;
      if (k < NG) begin
        p4 = x.op_a[4*k +: 4] ^ x.op_b[4*k +: 4];
        g4 = x.op_a[4*k +: 4] & x.op_b[4*k +: 4];
        c0 = y.cy;
        c1 = g4[0] | (p4[0] & c0);
        c2 = g4[1] | (p4[1] & g4[0])
           | (p4[1] & p4[0] & c0);
        c3 = g4[2] | (p4[2] & g4[1])
           | (p4[2] & p4[1] & g4[0])
           | (p4[2] & p4[1] & p4[0] & c0);
        gg = g4[3] | (p4[3] & g4[2])
           | (p4[3] & p4[2] & g4[1])
           | (p4[3] & p4[2] & p4[1] & g4[0]);
        gp = &p4;
        y.res[4*k +: 4] = p4 ^ {c3, c2, c1, c0};
        if (k == NG - 1) y.cm = c3;
        y.cy = gg | (gp & c0);
        y.gg = gg | (gp & y.gg);
        y.pp = y.pp & gp;
      end
    end
    return y;
  endfunction

  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;
  assign take      = in_valid & in_ready;
  assign out_valid = vld[NS-1];

  // Stage 0 sees the effective operands; later stages see registers
  always_comb begin
    in_st.op_a = a;
    in_st.op_b = sub ? ~b : b;
    in_st.res  = '0;
    in_st.cy   = sub ? ~cin : cin;
    in_st.pp   = 1'b1;
    in_st.gg   = 1'b0;
    in_st.cm   = 1'b0;
    nx[0] = calc(0, in_st);
    for (int s = 1; s < NS; s++) begin
      nx[s] = calc(s, r[s-1]);
    end
  end

  // Whole pipeline shifts together on adv, holds otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int s = 0; s < NS; s++) r[s] <= '0;
    end else if (adv) begin
      vld[0] <= take;
      if (take) r[0] <= nx[0];
      for (int s = 1; s < NS; s++) begin
        vld[s] <= vld[s-1];
        r[s]   <= nx[s];
      end
    end
  end

  assign sum  = r[NS-1].res;
  assign cout = r[NS-1].cy;
  assign ovf  = r[NS-1].cm ^ r[NS-1].cy;
  assign P    = r[NS-1].pp;
  assign G    = r[NS-1].gg;

endmodule
